// File: rtl/dtw_sdtw_engine.sv
// Systolic DTW engine: one cell per query sample; the reference streams through the array
// and the last-row costs are scored as global (mode 0) or subsequence (mode 1) DTW.
module dtw_sdtw_engine #(
    parameter int WIDTH    = 16,
    parameter int SQG_SIZE = 256,
    parameter int LEN_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] ref_len,
    input  logic             qry_valid,
    input  logic [WIDTH-1:0] qry_data,
    output logic             qry_ready,
    input  logic             ref_valid,
    input  logic [WIDTH-1:0] ref_data,
    output logic             ref_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] min_val,
    output logic [LEN_W-1:0] min_pos,
    output logic [LEN_W-1:0] dbg_cycle_counter
);

    localparam int              QC_W   = $clog2(SQG_SIZE + 1);
    localparam logic [WIDTH-1:0] INF   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
    localparam logic [LEN_W:0]   LAG   = (LEN_W + 1)'(SQG_SIZE - 1);
    localparam logic [LEN_W:0]   ONE   = (LEN_W + 1)'(1);
    localparam logic [QC_W-1:0]  Q_LAST = QC_W'(SQG_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_Q = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // All-ones is infinity; saturation keeps it absorbing.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH] ? INF : sum[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    state_t           state_r, state_s;
    logic             mode_r;
    logic [LEN_W-1:0] ref_len_r;
    logic [QC_W-1:0]  q_cnt_r;
    logic [LEN_W-1:0] adv_cnt_r;
    logic [WIDTH-1:0] min_val_r;
    logic [LEN_W-1:0] min_pos_r;

    logic [WIDTH-1:0] qry_r     [SQG_SIZE];
    logic [WIDTH-1:0] ref_r     [SQG_SIZE-1];
    logic [WIDTH-1:0] cost_r    [SQG_SIZE];
    logic [WIDTH-1:0] diag_r    [SQG_SIZE];
    logic [WIDTH-1:0] cost_nx_s [SQG_SIZE];

    logic             adv_s;
    logic             start_s;
    logic [WIDTH-1:0] ref_in_s;
    logic [WIDTH-1:0] row0_s;
    logic [LEN_W:0]   adv_nx_s;
    logic [LEN_W:0]   col_s;
    logic             score_s;
    logic             take_s;

    assign min_val           = min_val_r;
    assign min_pos           = min_pos_r;
    assign dbg_cycle_counter = adv_cnt_r;

    // Advance/score decode; col_s is the reference column the last cell finishes on this advance.
    always_comb begin
        start_s  = (state_r == S_IDLE) && start;
        adv_s    = ((state_r == S_RUN) && ref_valid) || (state_r == S_DRAIN);
        ref_in_s = (state_r == S_RUN) ? ref_data : ZERO;
        row0_s   = mode_r ? ZERO : INF;
        adv_nx_s = {1'b0, adv_cnt_r} + ONE;
        col_s    = adv_nx_s - LAG;
        score_s  = adv_s && (adv_nx_s > LAG) && (col_s <= {1'b0, ref_len_r});
        if (mode_r) begin
            take_s = cost_nx_s[SQG_SIZE-1] < min_val_r;
        end else begin
            take_s = col_s == {1'b0, ref_len_r};
        end
    end

    // Cell recurrence: up = previous cell's cost, left = own cost, diag = previous cell's older cost.
    always_comb begin
        cost_nx_s[0] = sat_add(abs_diff(qry_r[0], ref_in_s), min3(row0_s, cost_r[0], diag_r[0]));
        for (int i = 1; i < SQG_SIZE; i++) begin
            cost_nx_s[i] = sat_add(abs_diff(qry_r[i], ref_r[i-1]), min3(cost_r[i-1], cost_r[i], diag_r[i]));
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_s   = state_r;
        qry_ready = 1'b0;
        ref_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_LOAD_Q;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD_Q: begin
                qry_ready = 1'b1;
                busy      = 1'b1;
                if (qry_valid && (q_cnt_r == Q_LAST)) begin
                    state_s = (ref_len_r == {LEN_W{1'b0}}) ? S_DONE : S_RUN;
                end else begin
                    state_s = S_LOAD_Q;
                end
            end
            S_RUN: begin
                ref_ready = 1'b1;
                busy      = 1'b1;
                if (ref_valid && (adv_nx_s == {1'b0, ref_len_r})) begin
                    state_s = S_DRAIN;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (adv_nx_s == ({1'b0, ref_len_r} + LAG)) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job control: captured parameters, counters and the running best score.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r    <= 1'b0;
            ref_len_r <= {LEN_W{1'b0}};
            q_cnt_r   <= {QC_W{1'b0}};
            adv_cnt_r <= {LEN_W{1'b0}};
            min_val_r <= INF;
            min_pos_r <= {LEN_W{1'b0}};
        end else if (start_s) begin
            mode_r    <= mode;
            ref_len_r <= ref_len;
            q_cnt_r   <= {QC_W{1'b0}};
            adv_cnt_r <= {LEN_W{1'b0}};
            min_val_r <= INF;
            min_pos_r <= {LEN_W{1'b0}};
        end else if ((state_r == S_LOAD_Q) && qry_valid) begin
            q_cnt_r <= q_cnt_r + QC_W'(1);
        end else if (adv_s) begin
            adv_cnt_r <= adv_nx_s[LEN_W-1:0];
            if (score_s && take_s) begin
                min_val_r <= cost_nx_s[SQG_SIZE-1];
                min_pos_r <= col_s[LEN_W-1:0];
            end
        end
    end

    // Cell array: query load, reset of the cost wavefront on start, shift on each advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SQG_SIZE; i++) begin
                qry_r[i]  <= ZERO;
                cost_r[i] <= INF;
                diag_r[i] <= INF;
            end
            for (int i = 0; i < SQG_SIZE - 1; i++) begin
                ref_r[i] <= ZERO;
            end
        end else if (start_s) begin
            for (int i = 0; i < SQG_SIZE; i++) begin
                cost_r[i] <= INF;
                diag_r[i] <= (i == 0) ? ZERO : INF;
            end
        end else if ((state_r == S_LOAD_Q) && qry_valid) begin
            for (int i = 0; i < SQG_SIZE; i++) begin
                if (q_cnt_r == QC_W'(i)) begin
                    qry_r[i] <= qry_data;
                end
            end
        end else if (adv_s) begin
            ref_r[0]  <= ref_in_s;
            diag_r[0] <= row0_s;
            cost_r[0] <= cost_nx_s[0];
            for (int i = 1; i < SQG_SIZE; i++) begin
                diag_r[i] <= cost_r[i-1];
                cost_r[i] <= cost_nx_s[i];
            end
            for (int i = 1; i < SQG_SIZE - 1; i++) begin
                ref_r[i] <= ref_r[i-1];
            end
        end
    end

endmodule
